// File: rtl/vn_lut_update_ctrl.sv
// Loads a new VN LUT into the idle table half and swaps halves on an iteration boundary.
// Optional VN_LUT_SWAP_DRAIN_EN delays the swap until the two read pipeline stages have drained.
module vn_lut_update_ctrl #(
  parameter int QUAN_SIZE       = 3,
  parameter int LUT_PORT_SIZE   = 3,
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2,
  localparam int PW             = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM)
) (
  input  logic                     write_clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     lut_valid,
  output logic                     lut_ready,
  input  logic [LUT_PORT_SIZE-1:0] lut_data0,
  input  logic [LUT_PORT_SIZE-1:0] lut_data1,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
  output logic [PW-1:0]            page_write_addr,
  output logic                     write_addr_offset,
  output logic                     we,
  output logic                     read_addr_offset,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_err
);

  // The half select is a single bit, so only two table halves are supported.
  if (QUAN_SIZE < 1 || LUT_PORT_SIZE < 1 || MULTI_FRAME_NUM != 2 || PW < 1) begin : g_param_check
    $error("vn_lut_update_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t        state, state_next;
  logic [PW-1:0] beat_cnt, beat_cnt_next;
  logic          accept;
  logic          swap_fire;
  logic          swap_toggle;

`ifdef VN_LUT_SWAP_DRAIN_EN
  // Counts the drain cycles; whether to toggle is decided when the request arrives.
  logic [1:0] drain_cnt;
  logic       drain_toggle;

  always_ff @(posedge write_clk) begin
    if (rst) begin
      drain_cnt    <= 2'd0;
      drain_toggle <= 1'b0;
    end else if (drain_cnt == 2'd2) begin
      drain_cnt    <= 2'd0;
    end else if (drain_cnt != 2'd0) begin
      drain_cnt    <= drain_cnt + 2'd1;
    end else if (swap_req) begin
      drain_cnt    <= 2'd1;
      drain_toggle <= (state == WAIT_SWAP);
    end
  end

  assign swap_fire   = (drain_cnt == 2'd2);
  assign swap_toggle = drain_toggle;
`else
  assign swap_fire   = swap_req;
  assign swap_toggle = (state == WAIT_SWAP);
`endif

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    lut_ready     = 1'b0;
    load_busy     = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next    = LOAD;
          beat_cnt_next = '0;
        end
      end
      LOAD: begin
        lut_ready = 1'b1;
        load_busy = 1'b1;
        if (lut_valid) begin
          beat_cnt_next = beat_cnt + 1'b1;
          if (beat_cnt == '1) state_next = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        load_busy = 1'b1;
        if (swap_fire && swap_toggle) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept            = lut_valid & lut_ready;
  assign write_addr_offset = ~read_addr_offset;

  // Bank write data and page are only updated on an accepted beat.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      we               <= 1'b0;
      lut_in_bank0     <= '0;
      lut_in_bank1     <= '0;
      page_write_addr  <= '0;
      load_done        <= 1'b0;
      load_err         <= 1'b0;
      swap_ack         <= 1'b0;
      read_addr_offset <= 1'b0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_cnt_next;
      we        <= accept;
      load_done <= accept && (beat_cnt == '1);
      load_err  <= load_start && (state != IDLE);
      swap_ack  <= swap_fire;
      if (accept) begin
        lut_in_bank0    <= lut_data0;
        lut_in_bank1    <= lut_data1;
        page_write_addr <= beat_cnt;
      end
      if (swap_fire && swap_toggle) read_addr_offset <= ~read_addr_offset;
    end
  end

endmodule

// File: tb/tb_vn_lut_update_ctrl.sv
// Self-checking bench for vn_lut_update_ctrl: directed scenarios plus random traffic against a table-level model.
module tb_vn_lut_update_ctrl;

  localparam int LPS    = 3;
  localparam int PW     = 4;
  localparam int NBEATS = 16;

  logic           write_clk = 1'b0;
  logic           rst = 1'b1, load_start = 1'b0, lut_valid = 1'b0, swap_req = 1'b0;
  logic [LPS-1:0] lut_data0 = '0, lut_data1 = '0;
  logic           lut_ready, we, write_addr_offset, read_addr_offset;
  logic [LPS-1:0] lut_in_bank0, lut_in_bank1;
  logic [PW-1:0]  page_write_addr;
  logic           swap_ack, load_busy, load_done, load_err;

  vn_lut_update_ctrl dut (
    .write_clk(write_clk), .rst(rst), .load_start(load_start),
    .lut_valid(lut_valid), .lut_ready(lut_ready),
    .lut_data0(lut_data0), .lut_data1(lut_data1),
    .lut_in_bank0(lut_in_bank0), .lut_in_bank1(lut_in_bank1),
    .page_write_addr(page_write_addr), .write_addr_offset(write_addr_offset),
    .we(we), .read_addr_offset(read_addr_offset),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 write_clk = ~write_clk;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  // Reference view: is a table being streamed, is a finished table waiting, which half is live.
  bit           m_loading, m_pending, m_rd_half, m_drain_tog;
  int           m_beats, m_drain;
  bit           e_we, e_done, e_err, e_ack;
  int           e_page;
  logic [LPS-1:0] e_d0, e_d1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ls, input bit lv, input bit sr,
                               input logic [LPS-1:0] d0, input logic [LPS-1:0] d1);
    bit acc, tog, start;
    @(negedge write_clk);
    rst = r; load_start = ls; lut_valid = lv; swap_req = sr;
    lut_data0 = d0; lut_data1 = d1;
    #1;
    checkOutput("lut_ready", 32'(lut_ready), 32'(m_loading));
    checkOutput("load_busy", 32'(load_busy), 32'(m_loading || m_pending));
    checkOutput("write_addr_offset", 32'(write_addr_offset), 32'(!m_rd_half));
    if (r) begin
      m_loading = 0; m_pending = 0; m_rd_half = 0; m_beats = 0;
      m_drain = 0; m_drain_tog = 0;
      e_we = 0; e_done = 0; e_err = 0; e_ack = 0; e_page = 0; e_d0 = '0; e_d1 = '0;
    end else begin
      acc   = m_loading && lv;
      start = ls && !m_loading && !m_pending;
      e_we  = acc;
      if (acc) begin
        e_page = m_beats; e_d0 = d0; e_d1 = d1;
      end
      e_done = acc && (m_beats == NBEATS - 1);
      e_err  = ls && (m_loading || m_pending);
      tog    = 0;
      e_ack  = 0;
`ifdef VN_LUT_SWAP_DRAIN_EN
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) begin
          e_ack = 1;
          tog   = m_drain_tog;
        end
      end else if (sr) begin
        m_drain     = 2;
        m_drain_tog = m_pending;
      end
`else
      e_ack = sr;
      tog   = sr && m_pending;
`endif
      if (tog) begin
        m_rd_half = !m_rd_half;
        m_pending = 0;
      end
      if (acc) begin
        m_beats++;
        if (m_beats == NBEATS) begin
          m_loading = 0;
          m_pending = 1;
        end
      end
      if (start) begin
        m_loading = 1;
        m_beats   = 0;
      end
    end
    @(posedge write_clk);
    #1;
    if (we === 1'b1) we_count++;
    checkOutput("we", 32'(we), 32'(e_we));
    checkOutput("load_done", 32'(load_done), 32'(e_done));
    checkOutput("load_err", 32'(load_err), 32'(e_err));
    checkOutput("swap_ack", 32'(swap_ack), 32'(e_ack));
    checkOutput("read_addr_offset", 32'(read_addr_offset), 32'(m_rd_half));
    if (r || e_we) begin
      checkOutput("page_write_addr", 32'(page_write_addr), 32'(e_page));
      checkOutput("lut_in_bank0", 32'(lut_in_bank0), 32'(e_d0));
      checkOutput("lut_in_bank1", 32'(lut_in_bank1), 32'(e_d1));
    end
  endtask

  task automatic fullLoad();
    applyStimulus(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < NBEATS; i++) applyStimulus(0, 0, 1, 0, LPS'(i), ~LPS'(i));
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0);
    checkOutput("reset_read_offset", 32'(read_addr_offset), 32'd0);
    checkOutput("reset_write_offset", 32'(write_addr_offset), 32'd1);

    // Straight load of 16 pages, then swap.
    we_count = 0;
    fullLoad();
    checkOutput("load_write_count", 32'(we_count), 32'd16);
    applyStimulus(0, 0, 0, 1, '0, '0);
    checkOutput("swap_read_offset", 32'(read_addr_offset), 32'd1);
    applyStimulus(0, 0, 0, 0, '0, '0);

    // Valid only every other cycle.
    we_count = 0;
    applyStimulus(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 64 && we_count < NBEATS; i++)
      applyStimulus(0, 0, bit'(i % 2), 0, LPS'($urandom), LPS'($urandom));
    applyStimulus(0, 0, 0, 0, '0, '0);
    checkOutput("stall_write_count", 32'(we_count), 32'd16);
    applyStimulus(0, 0, 0, 1, '0, '0);

    // load_start and swap_req mid-load: rejected / acknowledged without toggle.
    we_count = 0;
    applyStimulus(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, LPS'(i), LPS'(i + 3));
    applyStimulus(0, 1, 1, 1, 3'd5, 3'd2);
    for (int i = 6; i < NBEATS; i++) applyStimulus(0, 0, 1, 0, LPS'(i), LPS'(i + 3));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, '0, '0);
    checkOutput("midload_write_count", 32'(we_count), 32'd16);
    applyStimulus(0, 0, 0, 1, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, '0, '0);

    // Reset after beat 7 abandons the load; a fresh load starts at page 0.
    we_count = 0;
    applyStimulus(0, 1, 0, 0, '0, '0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, LPS'(i), LPS'(7 - i));
    applyStimulus(1, 0, 1, 0, '1, '1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, '1, '1);
    checkOutput("abandon_write_count", 32'(we_count), 32'd8);
    fullLoad();

    // Swap request followed by a second one a cycle later.
    applyStimulus(0, 0, 0, 1, '0, '0);
    applyStimulus(0, 0, 0, 1, '0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, '0, '0);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
                    bit'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                    LPS'($urandom), LPS'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
